// File: rtl/memory_responder_pkg.sv
// mem_pkg: shared widths, address map and state types for memory_responder
//   WORD_W/OP_W set the instruction word; ADDR_W is the MAR slice width and
//   IO_ADDR is the top word, mapped to the digit display register.
package mem_pkg;
   localparam int WORD_W = 8;
   localparam int OP_W = 3;
   localparam int ADDR_W = WORD_W - OP_W;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int IO_ADDR = DEPTH - 1;
   typedef enum logic {IDLE, LOAD} resp_state_t;
   typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_IO} rd_src_t;
endpackage

// File: rtl/memory_responder_if.sv
// memory_responder_if: sequencer bus, program loader and display signals
//   master drives CS/R_NW/address/data_in and load_en/load_valid/load_data;
//   slave returns data_out/rd_valid/bus_err, load_full and digits/digit_strobe.
interface memory_responder_if;
   import mem_pkg::*;
   logic CS;
   logic R_NW;
   logic [ADDR_W-1:0] address;
   logic [WORD_W-1:0] data_in;
   logic [WORD_W-1:0] data_out;
   logic rd_valid;
   logic load_en;
   logic load_valid;
   logic [WORD_W-1:0] load_data;
   logic load_full;
   logic [WORD_W-1:0] digits;
   logic digit_strobe;
   logic bus_err;
   modport master (
      output CS, R_NW, address, data_in, load_en, load_valid, load_data,
      input data_out, rd_valid, load_full, digits, digit_strobe, bus_err
   );
   modport slave (
      input CS, R_NW, address, data_in, load_en, load_valid, load_data,
      output data_out, rd_valid, load_full, digits, digit_strobe, bus_err
   );
endinterface

// File: rtl/memory_responder_ram_1p.sv
// ram_1p: single-port word array with one write port and an enabled registered read
//   clock; we/wdata write addr; re loads q from addr; q holds between reads; no reset.
module ram_1p #(
   parameter int WORD_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] q
);
   logic [WORD_W-1:0] mem [2**ADDR_W];
   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      if (re) q <= mem[addr];
   end
endmodule

// File: rtl/memory_responder.sv
// memory_responder: registered read/write responder for the sequencer's CS/R_NW strobes
//   clock, reset (async, active-high); bus = memory_responder_if.slave carrying the
//   processor access, the auto-incrementing program loader and the digit display register.
module memory_responder
   import mem_pkg::*;
(
   input logic               clock,
   input logic               reset,
   memory_responder_if.slave bus
);
   resp_state_t state;
   rd_src_t src;
   logic [ADDR_W-1:0] ptr;
   logic [WORD_W-1:0] io_q, ram_q;
   logic io_hit, acc, rej, ld_wr;
   assign io_hit = bus.address == ADDR_W'(IO_ADDR);
   assign acc = bus.CS && state == IDLE && !bus.load_en;
   assign rej = bus.CS && !acc;
   assign ld_wr = state == LOAD && bus.load_valid && !bus.load_full;
   // Loader and processor never write in the same cycle: the loader only runs in LOAD,
   // processor accesses only in IDLE.
   ram_1p #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_ram (
      .clock (clock),
      .we    ((acc && !bus.R_NW && !io_hit) || ld_wr),
      .re    (acc && bus.R_NW && !io_hit),
      .addr  (state == LOAD ? ptr : bus.address),
      .wdata (state == LOAD ? bus.load_data : bus.data_in),
      .q     (ram_q)
   );
   // The array read register has no reset, so the last read's source picks the value
   // shown; io_q snapshots digits so later display writes do not disturb data_out.
   assign bus.data_out = src == SRC_RAM ? ram_q : src == SRC_IO ? io_q : '0;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         ptr <= '0;
         src <= SRC_ZERO;
         io_q <= '0;
         bus.rd_valid <= 1'b0;
         bus.digits <= '0;
         bus.digit_strobe <= 1'b0;
         bus.bus_err <= 1'b0;
         bus.load_full <= 1'b0;
      end else begin
         bus.rd_valid <= acc && bus.R_NW;
         bus.digit_strobe <= acc && !bus.R_NW && io_hit;
         if (rej) bus.bus_err <= 1'b1;
         if (acc && bus.R_NW) begin
            src <= io_hit ? SRC_IO : SRC_RAM;
            io_q <= bus.digits;
         end
         if (acc && !bus.R_NW && io_hit) bus.digits <= bus.data_in;
         if (state == IDLE && bus.load_en) begin
            state <= LOAD;
            ptr <= '0;
            bus.load_full <= 1'b0;
         end else if (state == LOAD && !bus.load_en) state <= IDLE;
         // The write into DEPTH-2 is the last one; IO_ADDR is never loaded.
         if (ld_wr) begin
            ptr <= ptr + 1'b1;
            bus.load_full <= ptr == ADDR_W'(DEPTH - 2);
         end
      end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed self-checking bench with a read-data scoreboard
module tb_memory_responder;
   import mem_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [WORD_W-1:0] sb [$];
   memory_responder_if bus ();
   memory_responder dut (.clock(clk), .reset(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic rd(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] e, input string tag);
      bus.CS = 1'b1;
      bus.R_NW = 1'b1;
      bus.address = a;
      sb.push_back(e);
      @(negedge clk);
      bus.CS = 1'b0;
      chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd1);
      chk(tag, 32'(bus.data_out), 32'(sb.pop_front()));
      @(negedge clk);
      chk({tag, "_rd_valid_drop"}, 32'(bus.rd_valid), 32'd0);
   endtask
   task automatic wr(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
      bus.CS = 1'b1;
      bus.R_NW = 1'b0;
      bus.address = a;
      bus.data_in = d;
      @(negedge clk);
      bus.CS = 1'b0;
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
      chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
      chk({tag, "_digits"}, 32'(bus.digits), 32'd0);
      chk({tag, "_digit_strobe"}, 32'(bus.digit_strobe), 32'd0);
      chk({tag, "_bus_err"}, 32'(bus.bus_err), 32'd0);
      chk({tag, "_load_full"}, 32'(bus.load_full), 32'd0);
   endtask
   initial begin
      logic [WORD_W-1:0] words [3] = '{8'h11, 8'h22, 8'h33};
      bus.CS = 1'b0;
      bus.R_NW = 1'b0;
      bus.address = '0;
      bus.data_in = '0;
      bus.load_en = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_data = '0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk);
      // load then read
      bus.load_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data = words[i];
         @(negedge clk);
      end
      bus.load_valid = 1'b0;
      bus.load_en = 1'b0;
      @(negedge clk);
      rd(5'd1, 8'h22, "load_rd1");
      rd(5'd0, 8'h11, "load_rd0");
      rd(5'd2, 8'h33, "load_rd2");
      // write / readback
      wr(5'd7, 8'hA5);
      chk("wr7_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("wr7_strobe", 32'(bus.digit_strobe), 32'd0);
      rd(5'd7, 8'hA5, "wr7_rd");
      chk("wr7_digits", 32'(bus.digits), 32'd0);
      // display register
      wr(5'd31, 8'h3C);
      chk("disp_digits", 32'(bus.digits), 32'h3C);
      chk("disp_strobe", 32'(bus.digit_strobe), 32'd1);
      @(negedge clk);
      chk("disp_strobe_drop", 32'(bus.digit_strobe), 32'd0);
      rd(5'd31, 8'h3C, "disp_rd");
      wr(5'd8, 8'h5A);
      chk("wr_keeps_data_out", 32'(bus.data_out), 32'h3C);
      rd(5'd8, 8'h5A, "wr8_rd");
      // loader saturation: 35 strobes, only 31 land
      bus.load_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 35; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data = 8'(8'h40 + i);
         @(negedge clk);
         if (i == 29) chk("sat_not_full_30", 32'(bus.load_full), 32'd0);
         if (i == 30) chk("sat_full_31", 32'(bus.load_full), 32'd1);
      end
      bus.load_valid = 1'b0;
      bus.load_en = 1'b0;
      @(negedge clk);
      chk("sat_full_held", 32'(bus.load_full), 32'd1);
      rd(5'd30, 8'h5E, "sat_rd30");
      rd(5'd0, 8'h40, "sat_rd0");
      rd(5'd29, 8'h5D, "sat_rd29");
      chk("sat_digits", 32'(bus.digits), 32'h3C);
      // rejected accesses: CS together with load_en rising, then a write in LOAD
      bus.load_en = 1'b1;
      bus.CS = 1'b1;
      bus.R_NW = 1'b1;
      bus.address = 5'd30;
      @(negedge clk);
      bus.CS = 1'b0;
      chk("rej_bus_err", 32'(bus.bus_err), 32'd1);
      chk("rej_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rej_data_out", 32'(bus.data_out), 32'h5D);
      chk("rej_load_full_clr", 32'(bus.load_full), 32'd0);
      wr(5'd0, 8'hFF);
      chk("rej_wr_rd_valid", 32'(bus.rd_valid), 32'd0);
      bus.load_en = 1'b0;
      @(negedge clk);
      chk("rej_bus_err_sticky", 32'(bus.bus_err), 32'd1);
      rd(5'd0, 8'h40, "rej_wr_dropped");
      chk("rej_bus_err_after", 32'(bus.bus_err), 32'd1);
      // reset in the middle of a load
      bus.load_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data = 8'(8'h90 + i);
         @(negedge clk);
      end
      bus.load_valid = 1'b0;
      bus.load_en = 1'b0;
      rst = 1'b1;
      #1;
      chk_reset("midload");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd(5'd0, 8'h90, "midload_rd0");
      rd(5'd4, 8'h94, "midload_rd4");
      rd(5'd5, 8'h45, "midload_rd5");
      bus.load_en = 1'b1;
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_data = 8'hEE;
      @(negedge clk);
      bus.load_valid = 1'b0;
      bus.load_en = 1'b0;
      @(negedge clk);
      rd(5'd0, 8'hEE, "reload_rd0");
      rd(5'd1, 8'h91, "reload_rd1");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
